// File: rtl/logic_sweep_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_sweep_pkg : state encoding, vector table, golden truth tables  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package logic_sweep_pkg;

  localparam int CNT_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit i of each table belongs to vector i; order {A,B} = 00, 10, 01, 11.
  localparam logic [3:0] VEC_A  = 4'b1010;
  localparam logic [3:0] VEC_B  = 4'b1100;
  localparam logic [3:0] GOLD_C = 4'b1000;
  localparam logic [3:0] GOLD_D = 4'b1110;
  localparam logic [3:0] GOLD_E = 4'b0110;

endpackage
`default_nettype wire

// File: rtl/logic_sweep_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_sweep_timer : dwell counter 0..DWELL-1, LAST on final count    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module logic_sweep_timer
  import logic_sweep_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  output logic [CNT_W-1:0] count,
  output logic             LAST
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (CLR) begin
      count_d = '0;
    end else if (EN) begin
      count_d = (count_q == LAST_CNT) ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign LAST  = (count_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/logic_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_sweep_checker : drives 4 {A,B} vectors, checks AND/OR/XOR DUT  |
// | Optional macro SWEEP_XOR_CHECK_EN enables checking of E (XOR).       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module logic_sweep_checker
  import logic_sweep_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       A,
  output logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_VEC
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  logic             busy;
  logic             start_go;
  logic             sample;
  logic             mismatch;
  logic [1:0]       idx_next;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_last;

  assign busy     = (state_q == ST_DRIVE);
  assign start_go = START & ~busy;
  assign idx_next = idx_q + 2'd1;
  // Sample strobe qualified on both the terminal flag and the count itself.
  assign sample   = busy & tmr_last & (tmr_count == LAST_CNT);

  logic_sweep_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (start_go),
    .EN    (busy),
    .count (tmr_count),
    .LAST  (tmr_last)
  );

`ifdef SWEEP_XOR_CHECK_EN
  assign mismatch = (C != GOLD_C[idx_q]) | (D != GOLD_D[idx_q]) | (E != GOLD_E[idx_q]);
`else
  // E is deliberately excluded from the verdict; the zero mask keeps the port consumed.
  assign mismatch = (C != GOLD_C[idx_q]) | (D != GOLD_D[idx_q]) | (E & 1'b0);
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    fail_vec_d = fail_vec_q;
    case (state_q)
      ST_DRIVE: begin
        if (sample) begin
          if (mismatch) begin
            fail_vec_d[idx_q] = 1'b1;
          end
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
            idx_d   = 2'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            idx_d = idx_next;
            a_d   = VEC_A[idx_next];
            b_d   = VEC_B[idx_next];
          end
        end
      end
      default: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (START) begin
          state_d    = ST_DRIVE;
          idx_d      = 2'd0;
          a_d        = VEC_A[0];
          b_d        = VEC_B[0];
          fail_vec_d = 4'b0000;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      fail_vec_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign BUSY     = busy;
  assign DONE     = (state_q == ST_DONE);
  assign PASS     = (state_q == ST_DONE) && (fail_vec_q == 4'b0000);
  assign FAIL_VEC = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_logic_sweep_checker : directed bench with a behavioural gate DUT  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_logic_sweep_checker;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a_o, b_o;
  logic       c_resp, d_resp, e_resp;
  logic       busy_o, done_o, pass_o;
  logic [3:0] fail_vec_o;

  // 0 golden, 1 C stuck-0, 2 D inverted, 3 E stuck-0, 4 all wrong except on sample cycles
  int   mode;
  logic corrupt;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic_sweep_checker #(
    .DWELL (DWELL)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .A        (a_o),
    .B        (b_o),
    .C        (c_resp),
    .D        (d_resp),
    .E        (e_resp),
    .BUSY     (busy_o),
    .DONE     (done_o),
    .PASS     (pass_o),
    .FAIL_VEC (fail_vec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    c_resp = a_o & b_o;
    d_resp = a_o | b_o;
    e_resp = a_o ^ b_o;
    case (mode)
      1: c_resp = 1'b0;
      2: d_resp = ~(a_o | b_o);
      3: e_resp = 1'b0;
      4: if (corrupt) begin
        c_resp = ~(a_o & b_o);
        d_resp = ~(a_o | b_o);
        e_resp = ~(a_o ^ b_o);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
  endtask

  // Advance to sweep cycle n, checking the driven vector on every cycle.
  task automatic run_to(input int n);
    int v;
    while (cyc < n) begin
      v = (cyc - 1) / DWELL;
      check("ab_vector", {30'd0, a_o, b_o}, {30'd0, v[0], v[1]});
      corrupt = (((cyc - 1) % DWELL) != (DWELL - 1));
      tick();
      cyc++;
    end
    corrupt = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [3:0] fv, input logic pass);
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass_o}, {31'd0, pass});
    check({tag, "_failvec"}, {28'd0, fail_vec_o}, {28'd0, fv});
    check({tag, "_ab_idle"}, {30'd0, a_o, b_o}, 32'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    mode    = 0;
    corrupt = 1'b0;
    cyc     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    tick();
    // Reset overrides a simultaneous START.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_pass", {31'd0, pass_o}, 32'd0);
    check("rst_failvec", {28'd0, fail_vec_o}, 32'd0);
    check("rst_ab", {30'd0, a_o, b_o}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // Golden sweep from IDLE.
    start_sweep();
    check("golden_busy", {31'd0, busy_o}, 32'd1);
    run_to(4 * DWELL);
    check("golden_not_done_yet", {31'd0, done_o}, 32'd0);
    run_to(4 * DWELL + 1);
    check_done("golden", 4'b0000, 1'b1);

    // C stuck at 0: only vector 3 (A=B=1) disagrees. Restarts from DONE.
    mode = 1;
    start_sweep();
    check("restart_done_drop", {31'd0, done_o}, 32'd0);
    check("restart_pass_drop", {31'd0, pass_o}, 32'd0);
    check("restart_failvec_clr", {28'd0, fail_vec_o}, 32'd0);
    run_to(4 * DWELL + 1);
    check_done("c_stuck0", 4'b1000, 1'b0);

    // D inverted: every vector disagrees.
    mode = 2;
    start_sweep();
    run_to(4 * DWELL + 1);
    check_done("d_inv", 4'b1111, 1'b0);

    // Golden sweep after a failure: PASS held low until the new sweep ends.
    mode = 0;
    start_sweep();
    check("refail_pass_start", {31'd0, pass_o}, 32'd0);
    run_to(10);
    check("refail_pass_mid", {31'd0, pass_o}, 32'd0);
    run_to(4 * DWELL + 1);
    check_done("after_fail", 4'b0000, 1'b1);

    // E stuck at 0: vectors 1 and 2 disagree only when E is checked.
    mode = 3;
    start_sweep();
    run_to(4 * DWELL + 1);
`ifdef SWEEP_XOR_CHECK_EN
    check_done("e_stuck0", 4'b0110, 1'b0);
`else
    check_done("e_stuck0", 4'b0000, 1'b1);
`endif

    // Responses wrong on every non-sample cycle must not matter.
    mode = 4;
    start_sweep();
    run_to(4 * DWELL + 1);
    check_done("off_sample_glitch", 4'b0000, 1'b1);

    // START at cycle 5 of a sweep is ignored.
    mode = 0;
    start_sweep();
    run_to(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc++;
    check("start_ignored_busy", {31'd0, busy_o}, 32'd1);
    check("start_ignored_ab", {30'd0, a_o, b_o}, 32'd2);
    run_to(4 * DWELL);
    check("start_ignored_c16", {31'd0, done_o}, 32'd0);
    run_to(4 * DWELL + 1);
    check_done("start_ignored", 4'b0000, 1'b1);

    // RST at cycle 9 aborts a failing sweep with nothing retained.
    mode = 2;
    start_sweep();
    run_to(9);
    check("pre_abort_failvec", {28'd0, fail_vec_o}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ab", {30'd0, a_o, b_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_pass", {31'd0, pass_o}, 32'd0);
    check("abort_failvec", {28'd0, fail_vec_o}, 32'd0);
    tick();
    tick();
    check("abort_stays_idle", {30'd0, busy_o, done_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_sweep_checker.md
LOGIC_SWEEP_CHECKER -- requirements
Module: logic_sweep_checker

Interface
REQ-001 Parameter: DWELL, default 100, clock cycles each input vector is held (legal 2..65535).
REQ-002 Port: CLK  input  1  single clock; all logic on rising edge.
REQ-003 Port: RST  input  1  synchronous, active-high reset.
REQ-004 Port: START  input  1  one-cycle request to begin a sweep.
REQ-005 Port: A  output  1  stimulus bit A to DUT.
REQ-006 Port: B  output  1  stimulus bit B to DUT.
REQ-007 Port: C  input  1  DUT response, expected A AND B.
REQ-008 Port: D  input  1  DUT response, expected A OR B.
REQ-009 Port: E  input  1  DUT response, expected A XOR B.
REQ-010 Port: BUSY  output  1  high while a sweep is in progress.
REQ-011 Port: DONE  output  1  high from sweep end until the next START or reset.
REQ-012 Port: PASS  output  1  valid while DONE; high iff no mismatch occurred.
REQ-013 Port: FAIL_VEC  output  4  bit i set if vector i mismatched.

Function
REQ-014 Vector order SHALL be fixed: index 0..3 = {A,B} 00, 10, 01, 11.
REQ-015 FSM SHALL have states IDLE, DRIVE, DONE.
REQ-016 IDLE or DONE with START=1 SHALL go to DRIVE next cycle, vector 0, dwell count 0, FAIL_VEC cleared.
REQ-017 In DRIVE, A/B SHALL be registered outputs equal to the current vector, changing only at vector boundaries.
REQ-018 Dwell counter SHALL run 0..DWELL-1 per vector; at count DWELL-1, C/D/E SHALL be compared to the golden values of the current vector.
REQ-019 A mismatch at that sample SHALL set FAIL_VEC[index] in the following cycle.
REQ-020 After sampling vector 3, FSM SHALL enter DONE; sweep length is exactly 4*DWELL cycles from the first DRIVE cycle.
REQ-021 In IDLE and DONE, A and B SHALL be 0.
REQ-022 BUSY SHALL equal (state==DRIVE); DONE SHALL equal (state==DONE).
REQ-023 PASS SHALL equal DONE AND (FAIL_VEC==0); PASS is 0 outside DONE.
REQ-024 START while BUSY SHALL be ignored; sweep continues unaffected.
REQ-025 START in DONE SHALL restart the sweep and drop DONE/PASS the next cycle.
REQ-026 DUT responses SHALL be ignored on all cycles other than the sample cycle.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, A=B=0, BUSY=DONE=PASS=0, FAIL_VEC=0, counter=0.
REQ-028 RST SHALL override START in the same cycle.
REQ-029 RST mid-sweep SHALL abort with no partial result retained.

Configuration
REQ-030 Macro SWEEP_XOR_CHECK_EN defined: E SHALL be compared per REQ-009.
REQ-031 Macro undefined: E SHALL be ignored, and mismatch SHALL depend on C and D only; the E port SHALL remain present.

Structure
REQ-032 Package logic_sweep_pkg SHALL hold the state enum, the 4-entry vector table, and the golden-function constants.
REQ-033 Dwell counter SHALL be sub-module logic_sweep_timer (inputs CLK, RST, CLR, EN; outputs count, LAST).

Verification
REQ-034 Golden DUT (C=A&B, D=A|B, E=A^B), DWELL=4, START pulse -> A/B 00,10,01,11 each for 4 cycles; DONE=1, PASS=1, FAIL_VEC=0000 at cycle 17.
REQ-035 DUT with C stuck at 0 -> FAIL_VEC=1000, PASS=0.
REQ-036 DUT with D inverted -> FAIL_VEC=1111, PASS=0.
REQ-037 DUT with E stuck at 0 -> with SWEEP_XOR_CHECK_EN: FAIL_VEC=0110; without it: FAIL_VEC=0000, PASS=1.
REQ-038 START at cycle 5 of a sweep -> no effect, DONE at cycle 17; RST at cycle 9 -> A=B=0, BUSY=0 next cycle, FAIL_VEC=0.
REQ-039 START in DONE after a failed sweep with a golden DUT -> PASS=0 during the new sweep, then PASS=1, FAIL_VEC=0000.
